es_mem_req_ctrl: RTL and testbench

//  EXE-stage load/store request controller, parametrised in data width and outstanding depth.

---
 rtl/es_mem_req_ctrl_pkg.sv | 35 +++
 rtl/es_meta_fifo.sv | 68 ++++++
 rtl/es_mem_req_ctrl.sv | 142 ++++++++++++++
 tb/tb_es_mem_req_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/es_mem_req_ctrl_pkg.sv
// Shared memory-op encodings, meta-entry layout and controller state type
// for the EXE-stage load/store request controller.
package es_mem_req_ctrl_pkg;

   localparam logic [1:0] MEM_SZ_B = 2'd0;
   localparam logic [1:0] MEM_SZ_H = 2'd1;
   localparam logic [1:0] MEM_SZ_W = 2'd2;
   localparam logic [1:0] MEM_SZ_D = 2'd3;

   localparam int MEM_META_WD = 6;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } mrc_state_e;

   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic [2:0] off;
   } mem_meta_t;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] mem_align_mask(input logic [1:0] sz);
      logic [2:0] m;
      case (sz)
         MEM_SZ_B: m = 3'b000;
         MEM_SZ_H: m = 3'b001;
         MEM_SZ_W: m = 3'b011;
         default:  m = 3'b111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/es_meta_fifo.sv
// Pointer FIFO for in-flight op metadata; head is combinational, same-cycle
// push+pop allowed (a pop frees a slot for a push even when full).
module es_meta_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_dat_i,
   input  logic                         pop_i,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [WIDTH-1:0]             head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed while counted.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_dat_i;
      end
   end

endmodule

// File: rtl/es_mem_req_ctrl.sv
// EXE-stage load/store request controller: 0-cycle issue, ALE detection,
// up to MAX_OUTST in-flight ops, in-order responses, drain after WB flush.
module es_mem_req_ctrl #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_OUTST = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              op_we,
   input  logic [1:0]        op_size,
   input  logic [AW-1:0]     op_addr,
   input  logic [DW-1:0]     op_wdata,
   output logic              op_ale,
   input  logic              flush,
   output logic              req,
   output logic              wr,
   output logic [1:0]        size,
   output logic [AW-1:0]     addr,
   output logic [DW/8-1:0]   wstrb,
   output logic [DW-1:0]     wdata,
   input  logic              addr_ok,
   input  logic              data_ok,
   input  logic [DW-1:0]     rdata,
   output logic              rsp_valid,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_we,
   output logic [1:0]        rsp_size,
   output logic [2:0]        rsp_off,
   output logic              busy,
   output logic              err_spurious
);

   import es_mem_req_ctrl_pkg::*;

   localparam int SW = DW / 8;
   localparam int LW = $clog2(SW);
   localparam int CW = $clog2(MAX_OUTST + 1);

   mrc_state_e                state_q;
   logic                      err_spurious_q;
   logic                      run;
   logic                      misaligned;
   logic                      push, pop, spurious;
   logic                      fifo_full, fifo_empty;
   logic [CW-1:0]             cnt, cnt_post;
   logic [SW-1:0]             strb_base;
   logic [MEM_META_WD-1:0]    head_raw;
   mem_meta_t                 meta_in, head_meta;

   // Reset also masks the handshake outputs so nothing leaks while held in reset.
   assign run        = (state_q == ST_RUN) && !reset;
   assign misaligned = ((op_size == MEM_SZ_D) && (DW == 32)) ||
                       (|(op_addr[2:0] & mem_align_mask(op_size)));

   assign op_ale   = op_valid && misaligned && run && !flush;
   assign req      = op_valid && !misaligned && run && !flush && !fifo_full;
   assign op_ready = op_ale || (req && addr_ok);

   assign wr   = op_we;
   assign size = op_size;
   assign addr = op_addr;

   always_comb begin
      case (op_size)
         MEM_SZ_B: strb_base = SW'(1);
         MEM_SZ_H: strb_base = SW'(3);
         MEM_SZ_W: strb_base = SW'(15);
         default:  strb_base = '1;
      endcase
      wstrb = op_we ? (strb_base << op_addr[LW-1:0]) : '0;
   end

   always_comb begin
      case (op_size)
         MEM_SZ_B: wdata = {SW{op_wdata[7:0]}};
         MEM_SZ_H: wdata = {(SW/2){op_wdata[15:0]}};
         MEM_SZ_W: wdata = {(DW/32){op_wdata[31:0]}};
         default:  wdata = op_wdata;
      endcase
   end

   assign push     = req && addr_ok;
   assign pop      = data_ok && !fifo_empty;
   assign spurious = data_ok && fifo_empty;
   assign cnt_post = cnt + CW'(push) - CW'(pop);

   assign meta_in = '{we: op_we, size: op_size, off: op_addr[2:0]};

   es_meta_fifo #(
      .WIDTH (MEM_META_WD),
      .DEPTH (MAX_OUTST)
   ) u_meta_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push),
      .push_dat_i (meta_in),
      .pop_i      (pop),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .head_o     (head_raw),
      .count_o    (cnt)
   );

   assign head_meta = mem_meta_t'(head_raw);

   // Stale responses still pop the FIFO (pop above) but never reach MEM.
   assign rsp_valid    = data_ok && !fifo_empty && run && !flush;
   assign rsp_rdata    = rdata;
   assign rsp_we       = head_meta.we;
   assign rsp_size     = head_meta.size;
   assign rsp_off      = head_meta.off;
   assign busy         = !fifo_empty;
   assign err_spurious = err_spurious_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_RUN;
         err_spurious_q <= 1'b0;
      end else begin
         if (spurious) begin
            err_spurious_q <= 1'b1;
         end
         case (state_q)
            ST_RUN: begin
               if (flush && (cnt_post != '0)) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pop && (cnt == CW'(1))) begin
                  state_q <= ST_RUN;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_es_mem_req_ctrl.sv
// Randomized bench for es_mem_req_ctrl with a queue-based model of in-flight
// ops and a scoreboard monitor that checks every response MEM receives.
module tb_es_mem_req_ctrl;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        op_valid = 0, op_we = 0, flush = 0, addr_ok = 0, data_ok = 0;
   logic [1:0]  op_size = 0;
   logic [31:0] op_addr = 0, op_wdata = 0, rdata = 0;
   logic        op_ready, op_ale, req, wr, rsp_valid, rsp_we, busy, err_spurious;
   logic [1:0]  size, rsp_size;
   logic [31:0] addr, wdata, rsp_rdata;
   logic [3:0]  wstrb;
   logic [2:0]  rsp_off;

   logic        d64_op_valid = 0, d64_op_we = 0;
   logic [1:0]  d64_op_size = 0;
   logic [31:0] d64_op_addr = 0;
   logic [63:0] d64_op_wdata = 0;
   logic        d64_op_ready, d64_op_ale, d64_req, d64_wr, d64_rsp_valid, d64_rsp_we;
   logic        d64_busy, d64_err_spurious;
   logic [1:0]  d64_size, d64_rsp_size;
   logic [31:0] d64_addr;
   logic [7:0]  d64_wstrb;
   logic [63:0] d64_wdata, d64_rsp_rdata;
   logic [2:0]  d64_rsp_off;

   es_mem_req_ctrl #(.AW(AW), .DW(DW), .MAX_OUTST(MAXO)) u_dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op_we(op_we),
      .op_size(op_size), .op_addr(op_addr), .op_wdata(op_wdata), .op_ale(op_ale),
      .flush(flush), .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb),
      .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_we(rsp_we), .rsp_size(rsp_size),
      .rsp_off(rsp_off), .busy(busy), .err_spurious(err_spurious)
   );

   es_mem_req_ctrl #(.AW(AW), .DW(64), .MAX_OUTST(MAXO)) u_dut64 (
      .clk(clk), .reset(reset), .op_valid(d64_op_valid), .op_ready(d64_op_ready),
      .op_we(d64_op_we), .op_size(d64_op_size), .op_addr(d64_op_addr),
      .op_wdata(d64_op_wdata), .op_ale(d64_op_ale), .flush(1'b0), .req(d64_req),
      .wr(d64_wr), .size(d64_size), .addr(d64_addr), .wstrb(d64_wstrb), .wdata(d64_wdata),
      .addr_ok(1'b0), .data_ok(1'b0), .rdata(64'd0), .rsp_valid(d64_rsp_valid),
      .rsp_rdata(d64_rsp_rdata), .rsp_we(d64_rsp_we), .rsp_size(d64_rsp_size),
      .rsp_off(d64_rsp_off), .busy(d64_busy), .err_spurious(d64_err_spurious)
   );

   typedef struct {
      logic       we;
      logic [1:0] sz;
      logic [2:0] off;
      bit         stale;
   } ent_t;

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic [2:0]  off;
      logic [31:0] rd;
   } rsp_t;

   ent_t infl[$];
   rsp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic bit misal(input logic [31:0] a, input logic [1:0] s, input int dw);
      return ((s == 2'd3) && (dw == 32)) || ((int'(a[2:0]) % (1 << s)) != 0);
   endfunction

   function automatic logic [7:0] exp_strb(input logic [31:0] a, input logic [1:0] s, input int sw);
      logic [7:0] r;
      int n, lo;
      r  = '0;
      n  = 1 << s;
      lo = int'(a[2:0]) % sw;
      for (int b = 0; b < sw; b++) r[b] = (b >= lo) && (b < lo + n);
      return r;
   endfunction

   function automatic logic [63:0] exp_wdata(input logic [63:0] d, input logic [1:0] s, input int sw);
      logic [63:0] r;
      int n;
      r = '0;
      n = 1 << s;
      for (int b = 0; b < sw; b++) r[8*b +: 8] = d[8*(b % n) +: 8];
      return r;
   endfunction

   // One bus cycle: drive, predict handshake, check, then advance the model.
   task automatic cyc(input logic v, input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic aok, input logic dok, input logic fl,
                      output logic acc);
      bit   mis, drn, e_ale, e_req, e_rdy;
      rsp_t r;
      ent_t e;
      @(posedge clk);
      #1;
      op_valid = v; op_we = we; op_size = sz; op_addr = a; op_wdata = wd;
      addr_ok = aok; data_ok = dok; flush = fl; rdata = $urandom;
      mis   = misal(a, sz, DW);
      drn   = (infl.size() > 0) && infl[0].stale;
      e_ale = v && mis && !drn && !fl;
      e_req = v && !mis && !drn && !fl && (infl.size() < MAXO);
      e_rdy = e_ale || (e_req && aok);
      if (dok && (infl.size() > 0) && !infl[0].stale && !fl) begin
         r.we = infl[0].we; r.sz = infl[0].sz; r.off = infl[0].off; r.rd = rdata;
         exp_q.push_back(r);
      end
      @(negedge clk);
      check("op_ready", op_ready, e_rdy);
      check("op_ale", op_ale, e_ale);
      check("req", req, e_req);
      check("busy", busy, infl.size() > 0);
      if (e_req) begin
         check("wr", wr, we);
         check("size", size, sz);
         check("addr", addr, a);
         check("wstrb", wstrb, we ? exp_strb(a, sz, 4) : 8'd0);
         check("wdata", wdata, exp_wdata(wd, sz, 4));
      end
      if (dok && (infl.size() > 0)) void'(infl.pop_front());
      if (e_req && aok) begin
         e.we = we; e.sz = sz; e.off = a[2:0]; e.stale = 1'b0;
         infl.push_back(e);
      end
      if (fl) foreach (infl[i]) infl[i].stale = 1'b1;
      acc = e_rdy;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      op_valid = 0; addr_ok = 0; data_ok = 0; flush = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_req", req, 1'b0);
      check("rst_op_ready", op_ready, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_err_spurious", err_spurious, 1'b0);
      check("rst_busy64", d64_busy, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      infl.delete();
   endtask

   initial begin
      logic        x, acc, cv, cwe;
      logic [1:0]  csz;
      logic [31:0] ca, cwd;
      logic [63:0] d;

      fork
         begin : monitor
            rsp_t m;
            forever begin
               @(negedge clk);
               if (rsp_valid === 1'b1) begin
                  if (exp_q.size() == 0) begin
                     n_cmp++;
                     n_bad++;
                     $display("FAIL rsp_unexpected: got rsp_valid=1 required 0 (t=%0t)", $time);
                  end else begin
                     m = exp_q.pop_front();
                     check("rsp_we", rsp_we, m.we);
                     check("rsp_size", rsp_size, m.sz);
                     check("rsp_off", rsp_off, m.off);
                     check("rsp_rdata", rsp_rdata, m.rd);
                  end
               end
            end
         end
      join_none

      do_reset();

      // store byte at 0x1003, then its response
      cyc(1, 1, 2'd0, 32'h1003, 32'hAB, 1, 0, 0, x);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, x);
      // misaligned word load, then size D on a 32-bit bus
      cyc(1, 0, 2'd2, 32'h1002, 32'h0, 1, 0, 0, x);
      cyc(1, 0, 2'd3, 32'h2008, 32'h0, 1, 0, 0, x);
      // three loads against a two-deep window
      cyc(1, 0, 2'd2, 32'h100, 32'h0, 1, 0, 0, x);
      cyc(1, 0, 2'd2, 32'h104, 32'h0, 1, 0, 0, x);
      cyc(1, 0, 2'd2, 32'h108, 32'h0, 1, 0, 0, x);
      cyc(1, 0, 2'd2, 32'h108, 32'h0, 1, 1, 0, x);
      cyc(1, 0, 2'd2, 32'h108, 32'h0, 1, 0, 0, x);
      // flush with two in flight: both responses are dropped, then issue resumes
      cyc(1, 0, 2'd2, 32'h200, 32'h0, 1, 0, 1, x);
      cyc(1, 0, 2'd2, 32'h200, 32'h0, 1, 1, 0, x);
      cyc(1, 0, 2'd2, 32'h200, 32'h0, 1, 1, 0, x);
      cyc(1, 0, 2'd2, 32'h200, 32'h0, 1, 0, 0, x);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, x);
      // flush while empty blocks the op for that cycle only
      cyc(1, 0, 2'd2, 32'h300, 32'h0, 1, 0, 1, x);
      cyc(1, 0, 2'd2, 32'h300, 32'h0, 1, 0, 0, x);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, x);
      // simultaneous issue and response at one outstanding
      cyc(1, 0, 2'd2, 32'h404, 32'h0, 1, 0, 0, x);
      cyc(1, 1, 2'd0, 32'h501, 32'h5A, 1, 1, 0, x);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, x);

      acc = 1'b0;
      cv  = 1'b0;
      cwe = 1'b0; csz = 2'd0; ca = '0; cwd = '0;
      for (int i = 0; i < 3000; i++) begin
         if (!cv || acc) begin
            cv  = ($urandom_range(0, 9) < 7);
            cwe = 1'($urandom_range(0, 1));
            csz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ca  = $urandom;
            if ($urandom_range(0, 4) != 0) ca = ca & ~((32'd1 << csz) - 32'd1);
            cwd = $urandom;
         end
         cyc(cv, cwe, csz, ca, cwd, $urandom_range(0, 2) != 0,
             (infl.size() > 0) && ($urandom_range(0, 9) < 4), $urandom_range(0, 29) == 0, acc);
      end
      for (int k = 0; (k < 8) && (infl.size() > 0); k++)
         cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, x);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, x);
      check("scoreboard_empty", exp_q.size(), 0);
      check("err_spurious_clean", err_spurious, 1'b0);

      // response with nothing outstanding is sticky until reset
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, x);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, x);
      check("err_spurious_set", err_spurious, 1'b1);
      cyc(1, 0, 2'd2, 32'h600, 32'h0, 1, 0, 0, x);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, x);
      check("err_spurious_held", err_spurious, 1'b1);

      // reset in the middle of two outstanding loads
      cyc(1, 0, 2'd2, 32'h700, 32'h0, 1, 0, 0, x);
      cyc(1, 0, 2'd2, 32'h704, 32'h0, 1, 0, 0, x);
      do_reset();
      cyc(1, 0, 2'd1, 32'h802, 32'h0, 1, 0, 0, x);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 1, 0, x);
      cyc(0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, x);
      check("scoreboard_empty_end", exp_q.size(), 0);

      // 64-bit instance: strobes and lane replication, never accepted
      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         #2;
         if (i == 0) begin
            csz = 2'd3; ca = 32'h2008; d = 64'h1122334455667788;
         end else begin
            csz = 2'($urandom_range(0, 3));
            ca  = $urandom & ~((32'd1 << csz) - 32'd1);
            d   = {$urandom, $urandom};
         end
         d64_op_valid = 1; d64_op_we = 1; d64_op_size = csz; d64_op_addr = ca; d64_op_wdata = d;
         #1;
         check("req64", d64_req, 1'b1);
         check("wstrb64", d64_wstrb, exp_strb(ca, csz, 8));
         check("wdata64", d64_wdata, exp_wdata(d, csz, 8));
      end
      @(posedge clk);
      #2;
      d64_op_size = 2'd3; d64_op_addr = 32'h2004;
      #1;
      check("ale64", d64_op_ale, 1'b1);
      check("req64_mis", d64_req, 1'b0);
      d64_op_valid = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
